// File: rtl/picobello_dummy_err_slv_pkg.sv
// AXI response encodings shared by the Picobello mesh blocks.
// Response codes are kept here so every tile decodes them identically.
package picobello_dummy_err_slv_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_DECERR = 2'b11;

endpackage : picobello_dummy_err_slv_pkg

// File: rtl/picobello_dummy_err_slv.sv
// Error slave placed at dummy mesh positions: completes every AXI read and write
// with DECERR and keeps a saturating count plus the address of the latest offender.
module picobello_dummy_err_slv
    import picobello_dummy_err_slv_pkg::*;
#(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64,
    parameter logic [63:0] RespData  = 64'hBADC_AB1E_DEAD_BEEF,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,

    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,

    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,

    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,

    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,

    output logic [CntWidth-1:0]  err_cnt_o,
    output logic [AddrWidth-1:0] err_addr_o
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    localparam logic [DataWidth-1:0] RESP_DATA_TRUNC = DataWidth'(RespData);

    logic [1:0]           r_wstate;
    logic [IdWidth-1:0]   r_bid;
    logic                 r_rstate;
    logic [IdWidth-1:0]   r_rid;
    logic [7:0]           r_beat_cnt;
    logic [CntWidth-1:0]  r_err_cnt;
    logic [AddrWidth-1:0] r_err_addr;

    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_ar_hs;
    logic                 w_r_hs;
    logic [1:0]           w_cnt_inc;
    logic [CntWidth:0]    w_cnt_sum;
    logic [CntWidth-1:0]  w_cnt_nxt;

    // Readies come from state only, so no valid-to-ready combinational path exists.
    assign aw_ready_o = (r_wstate == W_IDLE);
    assign w_ready_o  = (r_wstate == W_DATA);
    assign b_valid_o  = (r_wstate == W_RESP);
    assign b_id_o     = r_bid;
    assign b_resp_o   = b_valid_o ? RESP_DECERR : RESP_OKAY;

    assign ar_ready_o = (r_rstate == R_IDLE);
    assign r_valid_o  = (r_rstate == R_DATA);
    assign r_id_o     = r_rid;
    assign r_data_o   = r_valid_o ? RESP_DATA_TRUNC : '0;
    assign r_resp_o   = r_valid_o ? RESP_DECERR : RESP_OKAY;
    assign r_last_o   = r_valid_o && (r_beat_cnt == 8'd0);

    assign w_aw_hs = aw_valid_i && aw_ready_o;
    assign w_w_hs  = w_valid_i  && w_ready_o;
    assign w_ar_hs = ar_valid_i && ar_ready_o;
    assign w_r_hs  = r_valid_o  && r_ready_i;

    assign err_cnt_o  = r_err_cnt;
    assign err_addr_o = r_err_addr;

    // Write channel: accept AW, swallow W beats up to w_last, then answer on B.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wstate <= W_IDLE;
            r_bid    <= '0;
        end else begin
            // NOTE: state registers take <= so every flop samples pre-edge values.
            case (r_wstate)
                W_IDLE: if (w_aw_hs) begin
                    r_wstate <= W_DATA;
                    r_bid    <= aw_id_i;
                end
                W_DATA: if (w_w_hs && w_last_i) r_wstate <= W_RESP;
                W_RESP: if (b_ready_i) r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel: one DECERR beat per handshake until the loaded length runs out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rstate   <= R_IDLE;
            r_rid      <= '0;
            r_beat_cnt <= '0;
        end else if (w_ar_hs) begin
            r_rstate   <= R_DATA;
            r_rid      <= ar_id_i;
            r_beat_cnt <= ar_len_i;
        end else if (w_r_hs) begin
            if (r_beat_cnt == 8'd0) r_rstate <= R_IDLE;
            else                    r_beat_cnt <= r_beat_cnt - 8'd1;
        end
    end

    assign w_cnt_inc = {1'b0, w_aw_hs} + {1'b0, w_ar_hs};

    always_comb begin
        // NOTE: outputs of always_comb are assigned on every path to avoid latches.
        w_cnt_sum = {1'b0, r_err_cnt} + (CntWidth + 1)'(w_cnt_inc);
        w_cnt_nxt = w_cnt_sum[CntWidth-1:0];
        if (w_cnt_sum[CntWidth]) w_cnt_nxt = '1;
    end

    // A simultaneous AR wins the address capture over AW.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt  <= '0;
            r_err_addr <= '0;
        end else begin
            r_err_cnt <= w_cnt_nxt;
            if (w_ar_hs)      r_err_addr <= ar_addr_i;
            else if (w_aw_hs) r_err_addr <= aw_addr_i;
        end
    end

endmodule : picobello_dummy_err_slv

// File: tb/tb_picobello_dummy_err_slv.sv
// Bench for the dummy error slave: directed tables, hand sequences and random
// transactions scored against a transaction-level model of count and address.
module tb_picobello_dummy_err_slv;

    localparam logic [63:0] EXP_DATA = 64'hBADC_AB1E_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;
    logic [3:0]  aw_id, ar_id;
    logic [47:0] aw_addr, ar_addr;
    logic [7:0]  ar_len;

    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
    logic [3:0]  b_id, r_id;
    logic [1:0]  b_resp, r_resp;
    logic [63:0] r_data;
    logic [15:0] err_cnt;
    logic [47:0] err_addr;

    logic        s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid, s_r_last;
    logic [3:0]  s_b_id, s_r_id;
    logic [1:0]  s_b_resp, s_r_resp;
    logic [63:0] s_r_data;
    logic [3:0]  s_err_cnt;
    logic [47:0] s_err_addr;

    int          n_checks = 0;
    int          n_errs   = 0;
    int unsigned m_hs     = 0;
    logic [47:0] m_addr   = '0;

    always #5 clk = ~clk;

    picobello_dummy_err_slv u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
        .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .err_cnt_o(err_cnt), .err_addr_o(err_addr)
    );

    // Narrow-counter copy on the same stimulus, so saturation is reachable quickly.
    picobello_dummy_err_slv #(.CntWidth(4)) u_dut_sat (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_o(s_aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_o(s_w_ready), .w_last_i(w_last),
        .b_valid_o(s_b_valid), .b_ready_i(b_ready), .b_id_o(s_b_id), .b_resp_o(s_b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(s_ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
        .ar_len_i(ar_len),
        .r_valid_o(s_r_valid), .r_ready_i(r_ready), .r_id_o(s_r_id), .r_data_o(s_r_data),
        .r_resp_o(s_r_resp), .r_last_o(s_r_last),
        .err_cnt_o(s_err_cnt), .err_addr_o(s_err_addr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        logic [15:0] exp16;
        logic [3:0]  exp4;
        exp16 = (m_hs > 32'd65535) ? 16'hFFFF : m_hs[15:0];
        exp4  = (m_hs > 32'd15)    ? 4'hF     : m_hs[3:0];
        check({name, "_err_cnt"},     err_cnt,    exp16);
        check({name, "_err_cnt_sat"}, s_err_cnt,  exp4);
        check({name, "_err_addr"},    err_addr,   m_addr);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
        ar_valid = 1'b0; r_ready = 1'b0;
        aw_id = '0; ar_id = '0; aw_addr = '0; ar_addr = '0; ar_len = '0;
        m_hs   = 0;
        m_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode: 0 random r_ready, 1 r_ready toggling from 0, 2 r_ready always high
    task automatic do_read(input logic [3:0] id, input logic [7:0] len,
                           input logic [47:0] addr, input int mode);
        int   beats = 0;
        logic vld;
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len;
        check("ar_ready_idle", ar_ready, 1'b1);
        @(negedge clk);
        ar_valid = 1'b0;
        m_hs++;
        m_addr = addr;
        check_model("ar");
        check("r_first_latency", r_valid, 1'b1);
        for (int cyc = 0; cyc < 4 * (int'(len) + 1) + 8 && beats <= int'(len); cyc++) begin
            vld = r_valid;
            check("r_valid", r_valid, 1'b1);
            check("r_id", r_id, id);
            check("r_resp", r_resp, 2'b11);
            check("r_data", r_data, EXP_DATA);
            check("r_last", r_last, beats == int'(len));
            case (mode)
                0:       r_ready = ($urandom_range(0, 3) != 0);
                1:       r_ready = cyc[0];
                default: r_ready = 1'b1;
            endcase
            @(negedge clk);
            if (r_ready && vld) beats++;
        end
        r_ready = 1'b0;
        check("r_beats", beats, int'(len) + 1);
        check("r_valid_after_last", r_valid, 1'b0);
        check("ar_ready_after_last", ar_ready, 1'b1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [47:0] addr,
                            input int nbeats, input bit early);
        int  sent = 0;
        int  b_wait;
        bit  done = 0;
        if (early) begin
            w_valid = 1'b1;
            w_last  = (nbeats == 1);
            repeat (2) begin
                check("w_ready_before_aw", w_ready, 1'b0);
                @(negedge clk);
            end
        end
        aw_valid = 1'b1; aw_id = id; aw_addr = addr;
        check("aw_ready_idle", aw_ready, 1'b1);
        check("w_ready_in_idle", w_ready, 1'b0);
        @(negedge clk);
        aw_valid = 1'b0;
        m_hs++;
        m_addr = addr;
        check_model("aw");
        for (int cyc = 0; cyc < 4 * nbeats + 8 && sent < nbeats; cyc++) begin
            check("w_ready", w_ready, 1'b1);
            check("b_valid_during_w", b_valid, 1'b0);
            w_valid = early ? 1'b1 : ($urandom_range(0, 2) != 0);
            w_last  = (sent == nbeats - 1);
            @(negedge clk);
            if (w_valid) sent++;
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        check("w_beats", sent, nbeats);
        check("b_latency", b_valid, 1'b1);
        check("w_ready_in_resp", w_ready, 1'b0);
        b_wait = $urandom_range(0, 3);
        for (int c = 0; c < 10 && !done; c++) begin
            check("b_valid_held", b_valid, 1'b1);
            check("b_id", b_id, id);
            check("b_resp", b_resp, 2'b11);
            check("aw_ready_in_resp", aw_ready, 1'b0);
            b_ready = (c >= b_wait);
            @(negedge clk);
            if (b_ready) done = 1;
        end
        b_ready = 1'b0;
        check("b_valid_after", b_valid, 1'b0);
        check("aw_ready_after", aw_ready, 1'b1);
    endtask

    typedef struct {
        bit          is_read;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [47:0] addr;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 4'd1,  8'd3,   48'h0000_0000_A000, 16'd1};
        vecs[1] = '{1'b0, 4'd7,  8'd0,   48'h0000_0001_0000, 16'd2};
        vecs[2] = '{1'b1, 4'd15, 8'd0,   48'hFFFF_FFFF_FFF8, 16'd3};
        vecs[3] = '{1'b0, 4'd0,  8'd15,  48'h8000_0000_0000, 16'd4};
        vecs[4] = '{1'b1, 4'd10, 8'd255, 48'h1234_5678_9ABC, 16'd5};
        vecs[5] = '{1'b0, 4'd12, 8'd2,   48'h0000_DEAD_0040, 16'd6};

        do_reset();
        check("rst_aw_ready", aw_ready, 1'b1);
        check("rst_ar_ready", ar_ready, 1'b1);
        check("rst_w_ready", w_ready, 1'b0);
        check("rst_b_valid", b_valid, 1'b0);
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_err_cnt", err_cnt, 16'd0);
        check("rst_err_addr", err_addr, 48'd0);

        // Single-beat read
        do_read(4'd3, 8'd0, 48'h0000_0000_0300, 2);
        check("single_read_cnt", err_cnt, 16'd1);

        // Eight beats with r_ready toggling
        do_read(4'd5, 8'd7, 48'h0000_0000_0500, 1);

        // W presented before AW, then four beats
        do_write(4'd2, 48'h0000_0000_0200, 4, 1'b1);

        // Simultaneous AW and AR: +2 and AR address wins
        aw_valid = 1'b1; aw_id = 4'd1; aw_addr = 48'h1000;
        ar_valid = 1'b1; ar_id = 4'd6; ar_addr = 48'h2000; ar_len = 8'd0;
        check("sim_aw_ready", aw_ready, 1'b1);
        check("sim_ar_ready", ar_ready, 1'b1);
        @(negedge clk);
        aw_valid = 1'b0; ar_valid = 1'b0;
        m_hs += 2;
        m_addr = 48'h2000;
        check_model("sim");
        check("sim_err_addr_2000", err_addr, 48'h2000);
        check("sim_r_last", r_last, 1'b1);
        check("sim_r_id", r_id, 4'd6);
        r_ready = 1'b1; w_valid = 1'b1; w_last = 1'b1;
        @(negedge clk);
        r_ready = 1'b0; w_valid = 1'b0; w_last = 1'b0;
        check("sim_r_done", r_valid, 1'b0);
        check("sim_b_valid", b_valid, 1'b1);
        check("sim_b_id", b_id, 4'd1);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        check("sim_b_done", b_valid, 1'b0);

        // Directed table from a fresh reset
        do_reset();
        foreach (vecs[i]) begin
            if (vecs[i].is_read) do_read(vecs[i].id, vecs[i].len, vecs[i].addr, 0);
            else                 do_write(vecs[i].id, vecs[i].addr, int'(vecs[i].len) + 1, 1'b0);
            check($sformatf("vec%0d_err_cnt", i), err_cnt, vecs[i].exp_cnt);
            check($sformatf("vec%0d_err_addr", i), err_addr, vecs[i].addr);
        end

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            logic [3:0]  rid;
            logic [47:0] raddr;
            rid   = 4'($urandom_range(0, 15));
            raddr = {16'($urandom), $urandom};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 1)
                do_read(rid, 8'($urandom_range(0, 15)), raddr, 0);
            else
                do_write(rid, raddr, $urandom_range(1, 8), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of an eight-beat read
        ar_valid = 1'b1; ar_id = 4'd9; ar_addr = 48'h9000; ar_len = 8'd7;
        @(negedge clk);
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_r_valid", r_valid, 1'b0);
        check("midrst_err_cnt", err_cnt, 16'd0);
        check("midrst_err_addr", err_addr, 48'd0);
        r_ready = 1'b0;
        @(negedge clk);
        do_reset();
        check("postrst_r_valid", r_valid, 1'b0);
        check("postrst_ar_ready", ar_ready, 1'b1);
        do_read(4'd4, 8'd2, 48'h0000_0000_4400, 2);
        check("postrst_err_cnt", err_cnt, 16'd1);

        // Saturation of the narrow counter copy
        for (int k = 0; k < 15; k++) do_read(4'd1, 8'd0, 48'h100 + 48'(k), 2);
        check("sat_cnt_at_max", s_err_cnt, 4'hF);
        check("sat_wide_cnt", err_cnt, 16'd16);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule : tb_picobello_dummy_err_slv
